// File: rtl/nand_share_arbiter_pkg.sv
// Shared encodings for the NAND sharing arbiter and its fabric cell.
package nand_share_arbiter_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } stateT;

  // Rail pattern meaning the fabric is powered: [1]=high rail, [0]=low rail.
  localparam logic [1:0] SUPPLY_OK = 2'b10;

endpackage

// File: rtl/_nand.sv
// Fabric NAND cell: evaluates the wide NAND only while the rails are valid,
// otherwise the output collapses to the low rail.
module _nand
  import nand_share_arbiter_pkg::*;
#(
  parameter int unsigned INPUT_WIDTH = 8
) (
  input  logic [1:0]             DigitSupply,
  input  logic [INPUT_WIDTH-1:0] inputData,
  output logic                   outputData
);

  assign outputData = (DigitSupply == SUPPLY_OK) ? ~(&inputData) : 1'b0;

endmodule

// File: rtl/rr_pick.sv
// Round-robin picker: first set request scanning from rrPtr upward, modulo NUM_REQ.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         reqValid,
  input  logic [$clog2(NUM_REQ)-1:0] rrPtr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grantIdx,
  output logic                       anyValid
);

  localparam int unsigned PtrW = $clog2(NUM_REQ);

  logic [PtrW-1:0] idx;
  logic            found;

  // Scan rrPtr, rrPtr+1, ... and keep the first requester found.
  always_comb begin
    grant    = '0;
    grantIdx = '0;
    found    = 1'b0;
    idx      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = PtrW'((32'(rrPtr) + k) % NUM_REQ);
      if (!found && reqValid[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        grantIdx    = idx;
      end
    end
    anyValid = found;
  end

endmodule

// File: rtl/nand_share_arbiter.sv
// Time-shares one fabric NAND among NUM_REQ clients: round-robin grant,
// operand held SETTLE_CYCLES in the fabric, result held until consumed.
// SETTLE_CYCLES must be at least 1.
module nand_share_arbiter
  import nand_share_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned INPUT_WIDTH   = 8,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                           clock,
  input  logic                           resetN,
  input  logic [1:0]                     DigitSupply,
  input  logic [NUM_REQ-1:0]             reqValid,
  input  logic [NUM_REQ*INPUT_WIDTH-1:0] reqData,
  output logic [NUM_REQ-1:0]             reqReady,
  output logic [NUM_REQ-1:0]             rspValid,
  output logic                           rspData,
  input  logic                           rspReady,
  output logic                           busy
);

  localparam int unsigned PtrW = $clog2(NUM_REQ);
  localparam int unsigned CntW = $clog2(SETTLE_CYCLES) + 1;

  stateT                  state, stateNext;
  logic [PtrW-1:0]        rrPtr, rrPtrNext;
  logic [PtrW-1:0]        owner, ownerNext;
  logic [INPUT_WIDTH-1:0] opReg, opRegNext;
  logic                   resReg, resRegNext;
  logic [CntW-1:0]        cnt, cntNext;

  logic [NUM_REQ-1:0]     grant;
  logic [PtrW-1:0]        grantIdx;
  logic                   anyValid;
  logic                   nandOut;
  logic                   supplyOk;
  logic [INPUT_WIDTH-1:0] slice [NUM_REQ];

  assign supplyOk = (DigitSupply == SUPPLY_OK);

  for (genvar g = 0; g < NUM_REQ; g++) begin : gSlice
    assign slice[g] = reqData[g*INPUT_WIDTH +: INPUT_WIDTH];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) uPick (
    .reqValid (reqValid),
    .rrPtr    (rrPtr),
    .grant    (grant),
    .grantIdx (grantIdx),
    .anyValid (anyValid)
  );

  _nand #(
    .INPUT_WIDTH (INPUT_WIDTH)
  ) uNand (
    .DigitSupply (DigitSupply),
    .inputData   (opReg),
    .outputData  (nandOut)
  );

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state  <= ST_IDLE;
      rrPtr  <= '0;
      owner  <= '0;
      opReg  <= '0;
      resReg <= 1'b0;
      cnt    <= '0;
    end else begin
      state  <= stateNext;
      rrPtr  <= rrPtrNext;
      owner  <= ownerNext;
      opReg  <= opRegNext;
      resReg <= resRegNext;
      cnt    <= cntNext;
    end
  end

  // Next-state, handshake and response outputs.
  always_comb begin
    stateNext  = state;
    rrPtrNext  = rrPtr;
    ownerNext  = owner;
    opRegNext  = opReg;
    resRegNext = resReg;
    cntNext    = cnt;
    reqReady   = '0;
    rspValid   = '0;
    rspData    = 1'b0;
    busy       = (state != ST_IDLE);

    case (state)
      ST_IDLE: begin
        // No grant at all while the fabric rails are down.
        if (supplyOk && anyValid) begin
          reqReady = grant;
          if (|(reqValid & grant)) begin
            opRegNext = slice[grantIdx];
            ownerNext = grantIdx;
            cntNext   = CntW'(SETTLE_CYCLES - 1);
            stateNext = ST_SETTLE;
          end
        end
      end

      ST_SETTLE: begin
        if (cnt == '0) begin
          resRegNext = nandOut;
          stateNext  = ST_RESP;
        end else begin
          cntNext = cnt - CntW'(1);
        end
      end

      ST_RESP: begin
        rspValid = NUM_REQ'(1) << owner;
        rspData  = resReg;
        if (rspReady) begin
          stateNext = ST_IDLE;
          rrPtrNext = (32'(owner) == NUM_REQ - 1) ? '0 : owner + PtrW'(1);
        end
      end

      default: stateNext = ST_IDLE;
    endcase
  end

endmodule
